// File: rtl/cordic_sequencer.sv
// cordic_sequencer: multi-cycle CORDIC controller, one micro-rotation per clock.
// Accepts (x, y, z, mode, vectoring) over a valid/ready handshake and returns
// the final (x, y, z) over a second valid/ready handshake.
`timescale 1ns/1ps

module cordic_sequencer #(
   parameter int FIXED_WIDTH = 16,
   parameter int ITERATIONS  = 9
) (
   input  logic                          clk,
   input  logic                          rst_n,
   input  logic                          in_valid,
   output logic                          in_ready,
   input  logic signed [FIXED_WIDTH-1:0] in_x,
   input  logic signed [FIXED_WIDTH-1:0] in_y,
   input  logic signed [FIXED_WIDTH-1:0] in_z,
   input  logic [1:0]                    in_mode,
   input  logic                          in_vectoring,
   output logic                          out_valid,
   input  logic                          out_ready,
   output logic signed [FIXED_WIDTH-1:0] out_x,
   output logic signed [FIXED_WIDTH-1:0] out_y,
   output logic signed [FIXED_WIDTH-1:0] out_z,
   output logic                          out_err
);

   localparam int SW = 4;
   localparam logic [SW-1:0] LAST = SW'(ITERATIONS);

   typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
   typedef enum logic [1:0] {
      MODE_CIRC = 2'b00,
      MODE_LIN  = 2'b01,
      MODE_HYP  = 2'b10,
      MODE_ILL  = 2'b11
   } mode_t;

   state_t                   state, state_nx;
   logic [SW-1:0]            step;
   logic [SW-1:0]            shift;
   mode_t                    mode_q;
   logic                     vec_q;
   logic signed [FIXED_WIDTH-1:0] x_q, y_q, z_q;
   logic signed [FIXED_WIDTH-1:0] x_s, y_s, angle;
   logic signed [FIXED_WIDTH-1:0] x_nx, y_nx, z_nx;
   logic [15:0]              angle16;
   logic                     sigma_pos;
   logic                     accept;

   assign accept = in_valid && in_ready;

   // State register
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state <= IDLE;
      else        state <= state_nx;
   end

   // Next-state logic
   always_comb begin
      state_nx = state;
      case (state)
         IDLE:    if (in_valid)      state_nx = RUN;
         RUN:     if (step == LAST)  state_nx = DONE;
         DONE:    if (out_ready)     state_nx = IDLE;
         default:                    state_nx = IDLE;
      endcase
   end

   // Handshake outputs decoded from state
   always_comb begin
      in_ready  = (state == IDLE);
      out_valid = (state == DONE);
   end

   // Shift schedule: hyperbolic starts at 1 and repeats shift 4 once
   always_comb begin
      shift = step;
      if (mode_q == MODE_HYP)
         shift = (step < SW'(4)) ? step + SW'(1) : step;
   end

   // Angle constant for the current shift, Q2.14
   always_comb begin
      angle16 = 16'd16384 >> shift;
      case (mode_q)
         MODE_CIRC: begin
            case (shift)
               4'd0:    angle16 = 16'd12868;
               4'd1:    angle16 = 16'd7596;
               4'd2:    angle16 = 16'd4014;
               4'd3:    angle16 = 16'd2037;
               4'd4:    angle16 = 16'd1023;
               4'd5:    angle16 = 16'd512;
               4'd6:    angle16 = 16'd256;
               4'd7:    angle16 = 16'd128;
               4'd8:    angle16 = 16'd64;
               default: ;
            endcase
         end
         MODE_HYP: begin
            case (shift)
               4'd1:    angle16 = 16'd9000;
               4'd2:    angle16 = 16'd4185;
               4'd3:    angle16 = 16'd2059;
               4'd4:    angle16 = 16'd1025;
               4'd5:    angle16 = 16'd512;
               4'd6:    angle16 = 16'd256;
               4'd7:    angle16 = 16'd128;
               4'd8:    angle16 = 16'd64;
               default: ;
            endcase
         end
         default: ;
      endcase
      angle = $signed(FIXED_WIDTH'(angle16));
   end

   // Single micro-rotation step; illegal mode leaves the registers untouched
   always_comb begin
      x_s       = x_q >>> shift;
      y_s       = y_q >>> shift;
      sigma_pos = vec_q ? y_q[FIXED_WIDTH-1] : ~z_q[FIXED_WIDTH-1];
      x_nx      = x_q;
      y_nx      = y_q;
      z_nx      = z_q;
      case (mode_q)
         MODE_CIRC: begin
            x_nx = sigma_pos ? x_q - y_s   : x_q + y_s;
            y_nx = sigma_pos ? y_q + x_s   : y_q - x_s;
            z_nx = sigma_pos ? z_q - angle : z_q + angle;
         end
         MODE_LIN: begin
            y_nx = sigma_pos ? y_q + x_s   : y_q - x_s;
            z_nx = sigma_pos ? z_q - angle : z_q + angle;
         end
         MODE_HYP: begin
            x_nx = sigma_pos ? x_q + y_s   : x_q - y_s;
            y_nx = sigma_pos ? y_q + x_s   : y_q - x_s;
            z_nx = sigma_pos ? z_q - angle : z_q + angle;
         end
         default: ;
      endcase
   end

   // Operand latch, iteration registers, step counter and result registers.
   // step == ITERATIONS is a result-transfer cycle, giving ITERATIONS+1 clocks
   // from accept to out_valid.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         x_q     <= '0;
         y_q     <= '0;
         z_q     <= '0;
         mode_q  <= MODE_CIRC;
         vec_q   <= 1'b0;
         step    <= '0;
         out_x   <= '0;
         out_y   <= '0;
         out_z   <= '0;
         out_err <= 1'b0;
      end else if (accept) begin
         x_q     <= in_x;
         y_q     <= in_y;
         z_q     <= in_z;
         mode_q  <= mode_t'(in_mode);
         vec_q   <= in_vectoring;
         step    <= '0;
         out_err <= 1'b0;
      end else if (state == RUN) begin
         if (step != LAST) begin
            x_q  <= x_nx;
            y_q  <= y_nx;
            z_q  <= z_nx;
            step <= step + SW'(1);
         end else if (mode_q == MODE_ILL) begin
            out_x   <= '0;
            out_y   <= '0;
            out_z   <= '0;
            out_err <= 1'b1;
         end else begin
            out_x   <= x_q;
            out_y   <= y_q;
            out_z   <= z_q;
            out_err <= 1'b0;
         end
      end
   end

endmodule

// File: tb/tb_cordic_sequencer.sv
// tb_cordic_sequencer: directed and randomized operations on cordic_sequencer,
// checked every cycle against a timeline-plus-arithmetic reference model.
`timescale 1ns/1ps

module tb_cordic_sequencer;

   localparam int W = 16;
   localparam int N = 9;
   localparam int CIRC_TAB [9] = '{12868, 7596, 4014, 2037, 1023, 512, 256, 128, 64};
   localparam int HYP_TAB  [9] = '{0, 9000, 4185, 2059, 1025, 512, 256, 128, 64};
   localparam int HYP_SEQ  [9] = '{1, 2, 3, 4, 4, 5, 6, 7, 8};

   logic                clk = 1'b0;
   logic                rst_n = 1'b0;
   logic                in_valid = 1'b0;
   logic                in_ready;
   logic signed [W-1:0] in_x = '0, in_y = '0, in_z = '0;
   logic [1:0]          in_mode = 2'b00;
   logic                in_vectoring = 1'b0;
   logic                out_valid;
   logic                out_ready = 1'b0;
   logic signed [W-1:0] out_x, out_y, out_z;
   logic                out_err;

   int n_vec = 0;
   int n_err = 0;
   int cap_shift [16];

   always #5 clk = ~clk;

   cordic_sequencer #(.FIXED_WIDTH(W), .ITERATIONS(N)) dut (
      .clk(clk), .rst_n(rst_n),
      .in_valid(in_valid), .in_ready(in_ready),
      .in_x(in_x), .in_y(in_y), .in_z(in_z),
      .in_mode(in_mode), .in_vectoring(in_vectoring),
      .out_valid(out_valid), .out_ready(out_ready),
      .out_x(out_x), .out_y(out_y), .out_z(out_z),
      .out_err(out_err)
   );

   task automatic chk(input string name, input int act, input int exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
      end
   endtask

   function automatic int wrap(input int v);
      logic signed [W-1:0] t;
      t = v[W-1:0];
      return int'(t);
   endfunction

   // Unified CORDIC: x' = x + m*dir*(y>>>s), y' = y + dir*(x>>>s), z' = z - dir*angle
   function automatic void model_run(input int x0, input int y0, input int z0,
                                     input int mode, input bit vec,
                                     output int rx, output int ry, output int rz,
                                     output bit re);
      int x, y, z, s, d, dir, m, xn;
      bit rep;
      if (mode == 3) begin
         rx = 0; ry = 0; rz = 0; re = 1'b1;
         return;
      end
      x = x0; y = y0; z = z0; rep = 1'b0;
      s = (mode == 2) ? 1 : 0;
      m = (mode == 0) ? -1 : ((mode == 2) ? 1 : 0);
      for (int k = 0; k < N; k++) begin
         if (mode == 0)      d = (s < 9) ? CIRC_TAB[s] : (16384 >> s);
         else if (mode == 2) d = (s < 9) ? HYP_TAB[s]  : (16384 >> s);
         else                d = 16384 >> s;
         dir = (vec ? (y < 0) : (z >= 0)) ? 1 : -1;
         xn  = wrap(x + m * dir * (y >>> s));
         y   = wrap(y + dir * (x >>> s));
         z   = wrap(z - dir * d);
         x   = xn;
         if (mode == 2 && s == 4 && !rep) rep = 1'b1;
         else                             s++;
      end
      rx = x; ry = y; rz = z; re = 1'b0;
   endfunction

   // Reference timeline: busy from accept, valid N+1 clocks later, idle after transfer
   bit m_busy = 1'b0, m_valid = 1'b0, m_re = 1'b0, e_err = 1'b0;
   int m_cnt = 0, m_rx = 0, m_ry = 0, m_rz = 0, e_x = 0, e_y = 0, e_z = 0;

   always @(posedge clk or negedge rst_n) begin
      int tx, ty, tz;
      bit te;
      if (!rst_n) begin
         m_busy <= 1'b0; m_valid <= 1'b0; m_cnt <= 0;
         e_x <= 0; e_y <= 0; e_z <= 0; e_err <= 1'b0;
      end else if (!m_busy) begin
         if (in_valid) begin
            model_run(int'(in_x), int'(in_y), int'(in_z), int'(in_mode), in_vectoring,
                      tx, ty, tz, te);
            m_rx <= tx; m_ry <= ty; m_rz <= tz; m_re <= te;
            m_busy <= 1'b1; m_cnt <= 0; e_err <= 1'b0;
         end
      end else if (!m_valid) begin
         if (m_cnt + 1 == N + 1) begin
            m_valid <= 1'b1;
            e_x <= m_rx; e_y <= m_ry; e_z <= m_rz; e_err <= m_re;
         end
         m_cnt <= m_cnt + 1;
      end else if (out_ready) begin
         m_valid <= 1'b0;
         m_busy  <= 1'b0;
      end
   end

   // Every-cycle comparison against the reference model
   always @(negedge clk) begin
      chk("in_ready", int'(in_ready), int'(!m_busy));
      chk("out_valid", int'(out_valid), int'(m_valid));
      chk("out_x", int'(out_x), e_x);
      chk("out_y", int'(out_y), e_y);
      chk("out_z", int'(out_z), e_z);
      chk("out_err", int'(out_err), int'(e_err));
   end

   task automatic accept_op(input int x, input int y, input int z, input int mode, input bit vec);
      int guard = 0;
      while (!in_ready && guard < 100) begin
         @(posedge clk); #2;
         guard++;
      end
      chk("in_ready_wait", int'(in_ready), 1);
      in_valid = 1'b1;
      in_x = W'(x); in_y = W'(y); in_z = W'(z);
      in_mode = 2'(mode); in_vectoring = vec;
      @(posedge clk); #2;
      in_valid = 1'b0;
      in_x = W'($urandom); in_y = W'($urandom); in_z = W'($urandom);
      in_mode = 2'($urandom); in_vectoring = 1'($urandom);
   endtask

   task automatic wait_valid(output int lat);
      lat = 0;
      while (!out_valid && lat < 100) begin
         if (lat < N) cap_shift[lat] = int'(dut.shift);
         @(posedge clk); #2;
         lat++;
      end
      chk("latency", lat, N + 1);
   endtask

   task automatic do_op(input int x, input int y, input int z, input int mode, input bit vec);
      int lat;
      accept_op(x, y, z, mode, vec);
      wait_valid(lat);
   endtask

   task automatic finish_op(input int hold);
      repeat (hold) begin @(posedge clk); #2; end
      out_ready = 1'b1;
      @(posedge clk); #2;
      out_ready = 1'b0;
   endtask

   task automatic chk_out(input string name, input int x, input int y, input int z, input int err);
      chk({name, "_x"}, int'(out_x), x);
      chk({name, "_y"}, int'(out_y), y);
      chk({name, "_z"}, int'(out_z), z);
      chk({name, "_err"}, int'(out_err), err);
   endtask

   initial begin
      repeat (3) @(posedge clk);
      #2 rst_n = 1'b1;
      @(posedge clk); #2;
      chk("rst_in_ready", int'(in_ready), 1);
      chk("rst_out_valid", int'(out_valid), 0);
      chk_out("rst", 0, 0, 0, 0);

      // Hand-computed results pinning both DUT and model
      do_op(9950, 0, 12868, 0, 1'b0);
      chk_out("circ_rot", 11624, 11549, 54, 0);
      finish_op(1);
      do_op(8192, 8192, 0, 0, 1'b1);
      chk_out("circ_vec", 19078, 62, 12814, 0);
      finish_op(0);
      do_op(8192, 0, 8192, 1, 1'b0);
      chk_out("lin_rot", 8192, 4128, -64, 0);
      finish_op(2);
      do_op(16384, 8192, 0, 1, 1'b1);
      chk_out("lin_vec", 16384, -64, 8256, 0);
      finish_op(0);

      // Hyperbolic shift schedule
      do_op(12000, 0, 4000, 2, 1'b0);
      for (int k = 0; k < N; k++) chk($sformatf("hyp_shift%0d", k), cap_shift[k], HYP_SEQ[k]);
      finish_op(0);

      // Backpressure with a stray in_valid while DONE
      do_op(9950, 0, 12868, 0, 1'b0);
      for (int i = 0; i < 20; i++) begin
         if (i == 5) begin
            in_valid = 1'b1; in_x = 16'sd1000; in_y = 16'sd2000; in_mode = 2'b01;
         end
         if (i == 6) in_valid = 1'b0;
         @(posedge clk); #2;
         chk("bp_in_ready", int'(in_ready), 0);
         chk("bp_out_valid", int'(out_valid), 1);
         chk_out("bp", 11624, 11549, 54, 0);
      end
      finish_op(0);
      chk("rel_in_ready", int'(in_ready), 1);
      chk("rel_out_valid", int'(out_valid), 0);
      chk_out("rel_hold", 11624, 11549, 54, 0);

      // Illegal mode, then err clears on the next accept
      do_op(1234, -567, 890, 3, 1'b0);
      chk_out("illegal", 0, 0, 0, 1);
      finish_op(1);
      accept_op(8192, 8192, 0, 0, 1'b1);
      chk("err_clear", int'(out_err), 0);
      begin
         int lat;
         wait_valid(lat);
      end
      chk_out("circ_vec2", 19078, 62, 12814, 0);
      finish_op(0);

      // Asynchronous reset mid-RUN
      accept_op(16384, 8192, 0, 1, 1'b1);
      repeat (4) @(posedge clk);
      #1 rst_n = 1'b0;
      #1;
      chk("arst_out_valid", int'(out_valid), 0);
      chk("arst_in_ready", int'(in_ready), 1);
      chk_out("arst", 0, 0, 0, 0);
      @(posedge clk); #2 rst_n = 1'b1;
      do_op(9950, 0, 12868, 0, 1'b0);
      chk_out("post_rst", 11624, 11549, 54, 0);
      finish_op(0);

      // Randomized operations, gaps and backpressure
      for (int n = 0; n < 30; n++) begin
         int rx, ry, rz;
         rx = int'($urandom_range(0, 65535)) - 32768;
         ry = int'($urandom_range(0, 65535)) - 32768;
         rz = int'($urandom_range(0, 65535)) - 32768;
         repeat ($urandom_range(0, 2)) begin @(posedge clk); #2; end
         do_op(rx, ry, rz, int'($urandom_range(0, 3)), 1'($urandom));
         finish_op(int'($urandom_range(0, 3)));
      end

      repeat (2) @(posedge clk);
      #2;
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
